pb_debounce: RTL
================

# pb_debounce

Dual-channel pushbutton conditioner that sits directly upstream of the tug-of-war top level. It takes the raw left/right pushbutton pins and produces clean debounced levels for that block's `pbl`/`pbr` inputs, plus one-cycle press/release pulses and a held-too-long lockout so that a jammed or held button cannot register as a continuous press. It runs on the divided 500 Hz game clock (`clk`).

## Interface
- `DB_CYCLES`, default 10: consecutive stable samples required to accept a level change (20 ms at 500 Hz). Legal range is 2 or more.
- `STUCK_CYCLES`, default 1500: cycles a debounced press may stay high before lockout (3 s). Must be greater than `DB_CYCLES`.
- `clk` in 1: game clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pbl_raw` in 1: raw left pushbutton, asynchronous to `clk`.
- `pbr_raw` in 1: raw right pushbutton, asynchronous to `clk`.
- `pbl` out 1: debounced left level.
- `pbr` out 1: debounced right level.
- `pbl_rise` out 1: one-cycle pulse when `pbl` goes 0→1.
- `pbr_rise` out 1: one-cycle pulse when `pbr` goes 0→1.
- `pbl_fall` out 1: one-cycle pulse when `pbl` goes 1→0.
- `pbr_fall` out 1: one-cycle pulse when `pbr` goes 1→0.
- `pbl_stuck` out 1: left channel is locked out.
- `pbr_stuck` out 1: right channel is locked out.

## Operation
- The two channels are identical and fully independent. The description below is per channel; `s` is the synchronised raw input.
- Synchroniser: two flip-flops in series, reset to 0. `s` is the output of the second flip-flop.
- Counters:
  - `cnt`: debounce counter, width $clog2(DB_CYCLES+1).
  - `hold`: hold counter, width $clog2(STUCK_CYCLES+1).
  - Both saturate and never wrap.
- State machine:
  - IDLE (level 0):
    - `s`=1 → ARM_HI with `cnt`=1.
  - ARM_HI (level 0):
    - `s`=0 → IDLE, `cnt`=0.
    - `s`=1 and `cnt`==DB_CYCLES-1 → HIGH: level becomes 1, `rise` pulses, `hold`=0.
    - Otherwise `s`=1 → `cnt`+1.
  - HIGH (level 1):
    - `s`=0 → ARM_LO with `cnt`=1.
    - `s`=1 → `hold`+1.
    - `hold` reaching STUCK_CYCLES-1 → STUCK: level becomes 0, `fall` pulses, `stuck`=1.
  - ARM_LO (level 1):
    - `s`=1 → HIGH. `hold` is not cleared.
    - `s`=0 and `cnt`==DB_CYCLES-1 → IDLE: level becomes 0, `fall` pulses.
    - Otherwise `s`=0 → `cnt`+1.
    - `hold` also increments in ARM_LO, so bounce cannot extend a hold indefinitely.
  - STUCK (level 0, `stuck`=1):
    - `s`=0 → ARM_REL with `cnt`=1.
  - ARM_REL (level 0, `stuck`=1):
    - `s`=1 → STUCK, `cnt`=0.
    - `s`=0 and `cnt`==DB_CYCLES-1 → IDLE and `stuck` clears. No pulse.
    - Otherwise `s`=0 → `cnt`+1.
- Pulse rules:
  - Every 0→1 of the debounced level produces exactly one `rise`; every 1→0 produces exactly one `fall`.
  - `rise` and `fall` are never high together on the same channel.
- Simultaneous events: left and right may produce pulses in the same cycle. There is no arbitration here; tie and priority handling belongs downstream.

## Timing
- Reset (`rst`=0, asynchronous):
  - Every channel goes to IDLE with `cnt`=`hold`=0 and synchroniser flip-flops cleared.
  - All outputs read 0 immediately, with no clock edge needed.
- Reset deassertion:
  - The first state update occurs on the first rising edge after `rst` goes 1.
  - A raw input already high at release is treated as a new press and debounced normally.
- Reset asserted mid-operation (any state, including STUCK) drops all outputs to 0 at once, with no pulses.
- Press latency: edge E is the first edge sampling the raw input high.
  - `s`=1 after edge E+1.
  - `pbl` goes to 1 and `pbl_rise` pulses after edge E+1+DB_CYCLES, which is DB_CYCLES+2 edges counting E.
- Release latency is the same: DB_CYCLES+2 edges from the first edge sampling raw low.
- Outputs are registered with no combinational path from input to output.
  - Pulses are high for exactly one `clk` period.
- Lockout: for a held button, `stuck` rises STUCK_CYCLES cycles after `rise`, in the same cycle as `fall`.
- Glitch rejection: any raw high run shorter than DB_CYCLES sampled cycles produces no output change.

## Test plan
- Reset: drive `rst`=0 with both raw inputs high → all outputs 0 asynchronously. Release reset with inputs held → `pbl`/`pbr` rise, with pulses, 12 edges later (DB_CYCLES=10).
- Clean press: `pbl_raw` 0→1 held for 50 cycles then 0.
  - `pbl_rise` pulses once at edge 12; `pbl`=1.
  - `pbl_fall` pulses once 12 edges after release; right channel stays 0.
- Bounce: `pbl_raw` toggles with high runs of 3, 5 and 9 cycles, then stays high.
  - No output during the toggling.
  - Single `pbl_rise` 12 edges after the final stable high.
- Stuck: hold `pbr_raw` high with STUCK_CYCLES=40.
  - `pbr_rise` at edge 12.
  - `pbr_fall` and `pbr_stuck`=1 exactly 40 cycles later.
  - `pbr_stuck` clears 12 edges after release, with no extra pulse.
- Simultaneous: both raw inputs rise on the same edge → `pbl_rise` and `pbr_rise` in the same cycle.
- Reset mid-operation: assert `rst` while in ARM_LO → outputs 0 at once; no `fall` pulse after release.

Source files
------------

// File: rtl/pb_debounce_if.sv
// rtl/pb_debounce_if.sv - raw pushbutton pins in, conditioned levels and pulses out
interface pb_debounce_if;
  logic pbl_raw;
  logic pbr_raw;
  logic pbl;
  logic pbr;
  logic pbl_rise;
  logic pbr_rise;
  logic pbl_fall;
  logic pbr_fall;
  logic pbl_stuck;
  logic pbr_stuck;

  modport master (
    output pbl_raw, pbr_raw,
    input  pbl, pbr, pbl_rise, pbr_rise, pbl_fall, pbr_fall, pbl_stuck, pbr_stuck
  );

  modport slave (
    input  pbl_raw, pbr_raw,
    output pbl, pbr, pbl_rise, pbr_rise, pbl_fall, pbr_fall, pbl_stuck, pbr_stuck
  );
endinterface

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - dual-channel pushbutton debouncer with press/release pulses and held-button lockout
module pb_debounce_chan #(
  parameter int DB_CYCLES    = 10,
  parameter int STUCK_CYCLES = 1500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic stuck
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam int HW = $clog2(STUCK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DB_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(STUCK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(STUCK_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM_HI  = 3'd1,
    HIGH    = 3'd2,
    ARM_LO  = 3'd3,
    STUCK   = 3'd4,
    ARM_REL = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          stuck_q, stuck_d;
  logic          s;

  assign s        = sync2_q;
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    stuck_d = stuck_q;
    sync1_d = raw;
    sync2_d = sync1_q;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARM_HI;
          cnt_d   = CW'(1);
        end
      end
      ARM_HI: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HIGH: begin
        if (hold_q == HOLD_LAST) begin
          state_d = STUCK;
          level_d = 1'b0;
          fall_d  = 1'b1;
          stuck_d = 1'b1;
        end else if (!s) begin
          state_d = ARM_LO;
          cnt_d   = CW'(1);
          hold_d  = hold_inc;
        end else begin
          hold_d = hold_inc;
        end
      end
      ARM_LO: begin
        // hold keeps running here so a bouncing contact still ends in lockout
        if (!s && cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = STUCK;
          level_d = 1'b0;
          fall_d  = 1'b1;
          stuck_d = 1'b1;
        end else if (s) begin
          state_d = HIGH;
          hold_d  = hold_inc;
        end else begin
          cnt_d  = cnt_inc;
          hold_d = hold_inc;
        end
      end
      STUCK: begin
        if (!s) begin
          state_d = ARM_REL;
          cnt_d   = CW'(1);
        end
      end
      ARM_REL: begin
        if (s) begin
          state_d = STUCK;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          stuck_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 1'b0;
        stuck_d = 1'b0;
        cnt_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      stuck_q <= stuck_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign stuck = stuck_q;
endmodule

module pb_debounce #(
  parameter int DB_CYCLES    = 10,
  parameter int STUCK_CYCLES = 1500
) (
  input logic          clk,
  input logic          rst,
  pb_debounce_if.slave pb
);
  pb_debounce_chan #(
    .DB_CYCLES    (DB_CYCLES),
    .STUCK_CYCLES (STUCK_CYCLES)
  ) u_left (
    .clk   (clk),
    .rst_n (rst),
    .raw   (pb.pbl_raw),
    .level (pb.pbl),
    .rise  (pb.pbl_rise),
    .fall  (pb.pbl_fall),
    .stuck (pb.pbl_stuck)
  );

  pb_debounce_chan #(
    .DB_CYCLES    (DB_CYCLES),
    .STUCK_CYCLES (STUCK_CYCLES)
  ) u_right (
    .clk   (clk),
    .rst_n (rst),
    .raw   (pb.pbr_raw),
    .level (pb.pbr),
    .rise  (pb.pbr_rise),
    .fall  (pb.pbr_fall),
    .stuck (pb.pbr_stuck)
  );
endmodule
